// File: rtl/add_req_initiator.sv
// Requester for a start/valid adder engine: takes operand pairs upstream, issues one
// engine request at a time, and returns the result (or a timeout abort) downstream.
module add_req_initiator #(
  parameter int W       = 12,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] y,
  input  logic         valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_timeout,
  output logic [7:0]   timeout_count,
  output logic         proto_err,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high;
  // out_valid/out_sum/out_timeout stay stable until that edge.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_sum_q, out_sum_d;
  logic           out_timeout_q, out_timeout_d;
  logic [7:0]     tcnt_q, tcnt_d;
  logic           proto_err_q, proto_err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    a_d           = a_q;
    b_d           = b_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_timeout_d = out_timeout_q;
    tcnt_d        = tcnt_q;
    cnt_d         = cnt_q;
    // An engine valid anywhere but WAIT is a protocol violation; it never carries data.
    proto_err_d   = proto_err_q | (valid & (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A valid on the last allowed cycle still counts as a normal response.
        if (valid) begin
          out_sum_d     = y;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          out_sum_d     = '0;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_timeout_q <= 1'b0;
      tcnt_q        <= '0;
      proto_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      a_q           <= a_d;
      b_q           <= b_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_timeout_q <= out_timeout_d;
      tcnt_q        <= tcnt_d;
      proto_err_q   <= proto_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE) & ~rst;
  assign start         = start_q;
  assign a             = a_q;
  assign b             = b_q;
  assign out_valid     = out_valid_q;
  assign out_sum       = out_sum_q;
  assign out_timeout   = out_timeout_q;
  assign timeout_count = tcnt_q;
  assign proto_err     = proto_err_q;
  assign dbg_state     = state_q;

endmodule
